// File: rtl/pulse_symbol_timer.sv
// Symbol timer for the pulse transmitter: plays (level, duration) symbols on pulse_out with
// prescaled timing, optional carrier, and a one-deep pending slot for gapless back-to-back play.
module pulse_symbol_timer #(
    parameter int unsigned DUR_W   = 8,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned CAR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               carrier_en,
    input  logic [CAR_W-1:0]   carrier_half,
    input  logic               idle_level,
    input  logic               sym_valid,
    input  logic               sym_level,
    input  logic [DUR_W-1:0]   sym_dur,
    output logic               sym_ready,
    output logic               pulse_out,
    output logic               busy,
    output logic               sym_end
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic               level_q, level_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CAR_W-1:0]   car_cnt_q, car_cnt_d;
    logic [CAR_W-1:0]   car_half_q, car_half_d;
    logic               car_en_q, car_en_d;
    logic               phase_q, phase_d;
    logic               pend_v_q, pend_v_d;
    logic               pend_level_q, pend_level_d;
    logic [DUR_W-1:0]   pend_dur_q, pend_dur_d;
    logic               pulse_out_q, pulse_out_d;
    logic               busy_q, busy_d;
    logic               sym_end_q, sym_end_d;

    logic accept;
    logic last;
    logic load_new;
    logic load_pend;

    assign sym_ready = rst_n & enable & ~pend_v_q;
    assign accept    = sym_valid & sym_ready;
    assign last      = (dur_cnt_q == '0) && (presc_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        dur_cnt_d    = dur_cnt_q;
        presc_cnt_d  = presc_cnt_q;
        presc_d      = presc_q;
        car_cnt_d    = car_cnt_q;
        car_half_d   = car_half_q;
        car_en_d     = car_en_q;
        phase_d      = phase_q;
        pend_v_d     = pend_v_q;
        pend_level_d = pend_level_q;
        pend_dur_d   = pend_dur_q;
        sym_end_d    = 1'b0;
        load_new     = 1'b0;
        load_pend    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    load_new = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (presc_cnt_q == '0) begin
                    presc_cnt_d = presc_q;
                    if (dur_cnt_q != '0) dur_cnt_d = dur_cnt_q - DUR_W'(1);
                end else begin
                    presc_cnt_d = presc_cnt_q - PRESC_W'(1);
                end
                if (car_en_q) begin
                    if (car_cnt_q == '0) begin
                        car_cnt_d = car_half_q;
                        phase_d   = ~phase_q;
                    end else begin
                        car_cnt_d = car_cnt_q - CAR_W'(1);
                    end
                end
                if (last) begin
                    sym_end_d = 1'b1;
                    if (pend_v_q) begin
                        load_pend = 1'b1;
                        pend_v_d  = 1'b0;
                    end else if (accept) begin
                        load_new = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    // Accept implies an empty slot, so this never overwrites a pending symbol
                    pend_v_d     = 1'b1;
                    pend_level_d = sym_level;
                    pend_dur_d   = sym_dur;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_new || load_pend) begin
            level_d     = load_pend ? pend_level_q : sym_level;
            dur_cnt_d   = load_pend ? pend_dur_q : sym_dur;
            presc_cnt_d = prescale;
            presc_d     = prescale;
            car_cnt_d   = carrier_half;
            car_half_d  = carrier_half;
            car_en_d    = carrier_en;
            phase_d     = 1'b1;
        end

        if (!enable) begin
            state_d   = StIdle;
            pend_v_d  = 1'b0;
            sym_end_d = 1'b0;
        end

        // Outputs are registered from next-state values so they line up with the active symbol
        busy_d      = (state_d == StRun);
        pulse_out_d = busy_d ? (level_d & (car_en_d ? phase_d : 1'b1)) : idle_level;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            level_q      <= 1'b0;
            dur_cnt_q    <= '0;
            presc_cnt_q  <= '0;
            presc_q      <= '0;
            car_cnt_q    <= '0;
            car_half_q   <= '0;
            car_en_q     <= 1'b0;
            phase_q      <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_level_q <= 1'b0;
            pend_dur_q   <= '0;
            pulse_out_q  <= 1'b0;
            busy_q       <= 1'b0;
            sym_end_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            dur_cnt_q    <= dur_cnt_d;
            presc_cnt_q  <= presc_cnt_d;
            presc_q      <= presc_d;
            car_cnt_q    <= car_cnt_d;
            car_half_q   <= car_half_d;
            car_en_q     <= car_en_d;
            phase_q      <= phase_d;
            pend_v_q     <= pend_v_d;
            pend_level_q <= pend_level_d;
            pend_dur_q   <= pend_dur_d;
            pulse_out_q  <= pulse_out_d;
            busy_q       <= busy_d;
            sym_end_q    <= sym_end_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign sym_end   = sym_end_q;

endmodule

// File: tb/tb_pulse_symbol_timer.sv
// Bench for pulse_symbol_timer: per-cycle comparison against a symbol-level timeline model,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_pulse_symbol_timer;

    logic       clk = 1'b0;
    logic       rst_n, enable, carrier_en, idle_level, sym_valid, sym_level;
    logic [7:0] prescale, carrier_half, sym_dur;
    logic       sym_ready, pulse_out, busy, sym_end;

    pulse_symbol_timer #(.DUR_W(8), .PRESC_W(8), .CAR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .prescale     (prescale),
        .carrier_en   (carrier_en),
        .carrier_half (carrier_half),
        .idle_level   (idle_level),
        .sym_valid    (sym_valid),
        .sym_level    (sym_level),
        .sym_dur      (sym_dur),
        .sym_ready    (sym_ready),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .sym_end      (sym_end)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Timeline model: active symbol is (level, total length, elapsed cycles, carrier config)
    bit       m_run, m_pend, m_level, m_car, p_level;
    int       m_len, m_k, m_half;
    bit [7:0] p_dur;
    bit       m_pulse, m_busy, m_end;
    bit       last_acc;

    logic       sl [4];
    logic [7:0] sd [4];
    logic [63:0] rec_seq;
    int rec_len, rec_hi, rec_ends, rec_falls, rec_end_idle;
    bit rec_nr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input bit lvl, input bit [7:0] dur);
        m_run   = 1'b1;
        m_level = lvl;
        m_k     = 0;
        m_len   = (int'(dur) + 1) * (int'(prescale) + 1);
        m_car   = carrier_en;
        m_half  = int'(carrier_half);
    endtask

    task automatic model_step(input bit acc);
        bit last;
        m_end = 1'b0;
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_pulse = 0; m_busy = 0;
            return;
        end
        if (!enable) begin
            m_run = 0; m_pend = 0;
        end else if (!m_run) begin
            if (acc) load(sym_level, sym_dur);
        end else begin
            last = (m_k == m_len - 1);
            if (last) begin
                m_end = 1'b1;
                if (m_pend) begin
                    load(p_level, p_dur);
                    m_pend = 0;
                end else if (acc) begin
                    load(sym_level, sym_dur);
                end else begin
                    m_run = 0;
                end
            end else begin
                m_k++;
                if (acc) begin
                    m_pend = 1; p_level = sym_level; p_dur = sym_dur;
                end
            end
        end
        m_busy  = m_run;
        m_pulse = m_run ? (m_level & (!m_car || ((m_k / (m_half + 1)) % 2 == 0))) : idle_level;
    endtask

    // One clock: check sym_ready for the inputs now applied, advance the model, check outputs
    task automatic cycle();
        bit rdy;
        #1;
        rdy = rst_n & enable & ~m_pend;
        chk("sym_ready", sym_ready, rdy);
        last_acc = sym_valid & rdy;
        model_step(last_acc);
        @(negedge clk);
        chk("pulse_out", pulse_out, m_pulse);
        chk("busy", busy, m_busy);
        chk("sym_end", sym_end, m_end);
    endtask

    task automatic idle_cycles(input int n);
        sym_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic play(input int n, input int budget);
        int idx = 0;
        logic pb;
        rec_seq = '0; rec_len = 0; rec_hi = 0; rec_ends = 0; rec_falls = 0;
        rec_end_idle = 0; rec_nr = 0;
        pb = busy;
        for (int c = 0; c < budget; c++) begin
            sym_valid = (idx < n);
            if (idx < n) begin
                sym_level = sl[idx];
                sym_dur   = sd[idx];
            end
            cycle();
            if (last_acc) idx++;
            if (busy) begin
                rec_seq = {rec_seq[62:0], pulse_out};
                rec_len++;
                if (pulse_out) rec_hi++;
                if (!sym_ready) rec_nr = 1'b1;
            end
            if (sym_end) begin
                rec_ends++;
                if (!busy) rec_end_idle++;
            end
            if (pb && !busy) rec_falls++;
            pb = busy;
        end
        sym_valid = 1'b0;
        chk("all_accepted", idx, n);
    endtask

    initial begin
        logic [4:0] bseq;
        rst_n = 0; enable = 1; carrier_en = 0; idle_level = 0; sym_valid = 0;
        sym_level = 0; prescale = 0; carrier_half = 0; sym_dur = 0;
        m_run = 0; m_pend = 0; m_pulse = 0; m_busy = 0; m_end = 0;

        // Reset
        cycle(); cycle();
        chk("rst_ready_low", sym_ready, 1'b0);
        rst_n = 1;
        cycle();
        chk("rst_pulse", pulse_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_end", sym_end, 1'b0);
        chk("rst_ready_high", sym_ready, 1'b1);

        // Single symbol: 3 ticks of 2 cycles
        prescale = 1; sl[0] = 1; sd[0] = 2;
        play(1, 12);
        chk("single_hi", rec_hi, 6);
        chk("single_busy", rec_len, 6);
        chk("single_ends", rec_ends, 1);
        chk("single_end_idle", rec_end_idle, 1);

        // Back-to-back
        idle_cycles(2);
        prescale = 0;
        sl[0] = 1; sd[0] = 1; sl[1] = 0; sd[1] = 0; sl[2] = 1; sd[2] = 2;
        play(3, 12);
        chk("b2b_seq", rec_seq[5:0], 6'b110111);
        chk("b2b_len", rec_len, 6);
        chk("b2b_ends", rec_ends, 3);
        chk("b2b_falls", rec_falls, 1);
        chk("b2b_notready", rec_nr, 1'b1);

        // Carrier
        idle_cycles(2);
        carrier_en = 1; carrier_half = 1;
        sl[0] = 1; sd[0] = 7; sl[1] = 0; sd[1] = 3;
        play(2, 16);
        chk("car_seq", rec_seq[11:0], 12'b110011000000);
        chk("car_len", rec_len, 12);
        carrier_en = 0; carrier_half = 0;

        // Disable mid-symbol with a pending symbol
        idle_cycles(2);
        idle_level = 1;
        sym_valid = 1; sym_level = 1; sym_dur = 9;
        cycle();
        chk("dis_acc_a", last_acc, 1'b1);
        sym_level = 0; sym_dur = 0;
        cycle();
        chk("dis_acc_b", last_acc, 1'b1);
        sym_valid = 0;
        cycle();
        enable = 0;
        cycle();
        chk("dis_busy", busy, 1'b0);
        chk("dis_pulse", pulse_out, 1'b1);
        chk("dis_end", sym_end, 1'b0);
        rec_ends = 0;
        repeat (3) begin
            cycle();
            if (sym_end) rec_ends++;
        end
        chk("dis_no_end", rec_ends, 0);
        enable = 1;
        #1;
        chk("reen_ready", sym_ready, 1'b1);
        rec_len = 0;
        repeat (4) begin
            cycle();
            if (busy) rec_len++;
        end
        chk("pend_discarded", rec_len, 0);
        idle_level = 0;

        // Shortest symbol
        sl[0] = 1; sd[0] = 0;
        play(1, 4);
        chk("min_hi", rec_hi, 1);
        chk("min_len", rec_len, 1);

        // Accept in the final cycle with an empty pending slot
        idle_cycles(2);
        sym_valid = 1; sym_level = 1; sym_dur = 2;
        cycle();
        sym_valid = 0;
        bseq[4] = busy;
        cycle(); bseq[3] = busy;
        cycle(); bseq[2] = busy;
        sym_valid = 1; sym_level = 0; sym_dur = 1;
        cycle();
        chk("final_acc", last_acc, 1'b1);
        chk("final_end", sym_end, 1'b1);
        chk("final_pulse", pulse_out, 1'b0);
        bseq[1] = busy;
        sym_valid = 0;
        cycle(); bseq[0] = busy;
        cycle();
        chk("final_busy_seq", bseq, 5'b11111);
        chk("final_idle", busy, 1'b0);

        // Longest symbol
        idle_cycles(2);
        prescale = 255; sl[0] = 1; sd[0] = 255;
        play(1, 65545);
        chk("max_len", rec_len, 65536);
        chk("max_hi", rec_hi, 65536);
        chk("max_ends", rec_ends, 1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            enable       = ($urandom_range(0, 79) != 0);
            sym_valid    = $urandom_range(0, 1);
            sym_level    = $urandom_range(0, 1);
            sym_dur      = 8'($urandom_range(0, 5));
            prescale     = 8'($urandom_range(0, 2));
            carrier_en   = $urandom_range(0, 1);
            carrier_half = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) idle_level = ~idle_level;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
